// File: rtl/ritc_phase_scan_controller.sv
// ritc_phase_scan_controller: steps the MMCM phase shift, settles, then counts high samples of one RITC input
module ritc_phase_scan_controller #(
    parameter int          NSAMPLE_BITS      = 8,
    parameter int          SETTLE_CYCLES     = 16,
    parameter int          PS_TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] PHASE_RESET       = 16'd0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SCAN_START,
    input  logic                  SCAN_STEP,
    input  logic                  SCAN_DIR,
    input  logic [5:0]            SCAN_SEL,
    input  logic [2:0]            CLOCK_IN,
    input  logic [11:0]           CH0_IN,
    input  logic [11:0]           CH1_IN,
    input  logic [11:0]           CH2_IN,
    input  logic                  VCDL_IN,
    output logic                  PSEN,
    output logic                  PSINCDEC,
    input  logic                  PSDONE,
    output logic [NSAMPLE_BITS:0] RESULT,
    output logic                  RESULT_VALID,
    input  logic                  RESULT_ACK,
    output logic                  BUSY,
    output logic [15:0]           PHASE_POS,
    output logic                  PS_TIMEOUT
);
    localparam int AW = NSAMPLE_BITS + 1;
    localparam int TW = $clog2(PS_TIMEOUT_CYCLES);
    localparam int MW = TW > NSAMPLE_BITS ? TW : NSAMPLE_BITS;
    localparam int CW = MW > 8 ? MW : 8;
    localparam logic [CW-1:0] T_LAST = CW'(PS_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] N_LAST = CW'((1 << NSAMPLE_BITS) - 1);

    typedef enum logic [2:0] {IDLE, PS_REQ, PS_WAIT, SETTLE, SAMPLE, HOLD} state_t;

    state_t        state;
    logic [5:0]    sel_q;
    logic          dir_q;
    logic [CW-1:0] cnt;
    logic [AW-1:0] acc;
    logic [63:0]   src;
    logic          sample_bit;

    // selects above 39 land on the zero padding, so they count nothing
    assign src = {24'd0, VCDL_IN, CH2_IN, CH1_IN, CH0_IN, CLOCK_IN};
    assign sample_bit = src[sel_q];

    // scan sequencer: one shared counter serves timeout, settle and sample windows
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            sel_q        <= '0;
            dir_q        <= 1'b0;
            cnt          <= '0;
            acc          <= '0;
            PSEN         <= 1'b0;
            PSINCDEC     <= 1'b0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
            BUSY         <= 1'b0;
            PHASE_POS    <= PHASE_RESET;
            PS_TIMEOUT   <= 1'b0;
        end else begin
            PSEN <= 1'b0;
            case (state)
                IDLE: if (SCAN_START) begin
                    sel_q      <= SCAN_SEL;
                    dir_q      <= SCAN_DIR;
                    PS_TIMEOUT <= 1'b0;
                    BUSY       <= 1'b1;
                    cnt        <= '0;
                    PSEN       <= SCAN_STEP;
                    PSINCDEC   <= SCAN_STEP ? SCAN_DIR : PSINCDEC;
                    state      <= SCAN_STEP ? PS_REQ : SETTLE;
                end
                PS_REQ: begin
                    cnt   <= '0;
                    state <= PS_WAIT;
                end
                PS_WAIT: if (PSDONE) begin
                    PHASE_POS <= PHASE_POS + (dir_q ? 16'h0001 : 16'hffff);
                    cnt       <= '0;
                    state     <= SETTLE;
                end else if (cnt == T_LAST) begin
                    PS_TIMEOUT <= 1'b1;
                    BUSY       <= 1'b0;
                    state      <= IDLE;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                SETTLE: if (cnt == S_LAST) begin
                    cnt   <= '0;
                    acc   <= '0;
                    state <= SAMPLE;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                SAMPLE: begin
                    acc <= acc + AW'(sample_bit);
                    cnt <= cnt + CW'(1);
                    if (cnt == N_LAST) begin
                        RESULT       <= acc + AW'(sample_bit);
                        RESULT_VALID <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: if (RESULT_ACK) begin
                    RESULT_VALID <= 1'b0;
                    BUSY         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ritc_phase_scan_controller.sv
// tb_ritc_phase_scan_controller: scoreboard bench for the phase scan controller
module tb_ritc_phase_scan_controller;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        SCAN_START = 1'b0, SCAN_STEP = 1'b0, SCAN_DIR = 1'b0;
    logic [5:0]  SCAN_SEL = 6'd0;
    logic [2:0]  CLOCK_IN = 3'd0;
    logic [11:0] CH0_IN, CH1_IN = 12'd0, CH2_IN = 12'd0;
    logic        VCDL_IN = 1'b0, PSDONE = 1'b0, RESULT_ACK = 1'b0;
    logic        PSEN, PSINCDEC, RESULT_VALID, BUSY, PS_TIMEOUT;
    logic [8:0]  RESULT;
    logic [15:0] PHASE_POS;

    logic        s2_start = 1'b0, s2_done = 1'b0, s2_ack = 1'b0;
    logic        psen2, psincdec2, valid2, busy2, to2;
    logic [1:0]  result2;
    logic [15:0] pos2;

    typedef struct {int res; int at;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0, n_tests = 0, n_fail = 0, psen_cnt = 0;
    logic tog = 1'b0, prev_v = 1'b0;

    ritc_phase_scan_controller u0 (
        .CLK(CLK), .RST(RST), .SCAN_START(SCAN_START), .SCAN_STEP(SCAN_STEP), .SCAN_DIR(SCAN_DIR),
        .SCAN_SEL(SCAN_SEL), .CLOCK_IN(CLOCK_IN), .CH0_IN(CH0_IN), .CH1_IN(CH1_IN), .CH2_IN(CH2_IN),
        .VCDL_IN(VCDL_IN), .PSEN(PSEN), .PSINCDEC(PSINCDEC), .PSDONE(PSDONE), .RESULT(RESULT),
        .RESULT_VALID(RESULT_VALID), .RESULT_ACK(RESULT_ACK), .BUSY(BUSY), .PHASE_POS(PHASE_POS),
        .PS_TIMEOUT(PS_TIMEOUT)
    );

    ritc_phase_scan_controller #(
        .NSAMPLE_BITS(1), .SETTLE_CYCLES(1), .PS_TIMEOUT_CYCLES(8), .PHASE_RESET(16'd32765)
    ) u1 (
        .CLK(CLK), .RST(RST), .SCAN_START(s2_start), .SCAN_STEP(SCAN_STEP), .SCAN_DIR(SCAN_DIR),
        .SCAN_SEL(SCAN_SEL), .CLOCK_IN(CLOCK_IN), .CH0_IN(CH0_IN), .CH1_IN(CH1_IN), .CH2_IN(CH2_IN),
        .VCDL_IN(VCDL_IN), .PSEN(psen2), .PSINCDEC(psincdec2), .PSDONE(s2_done), .RESULT(result2),
        .RESULT_VALID(valid2), .RESULT_ACK(s2_ack), .BUSY(busy2), .PHASE_POS(pos2),
        .PS_TIMEOUT(to2)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) CH0_IN = tog ? {11'd0, ~CH0_IN[0]} : 12'd0;

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (PSEN) psen_cnt++;
        if (RESULT_VALID && !prev_v) begin
            chk("sb_pending", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("result", int'(RESULT), mon_e.res);
                if (mon_e.at >= 0) chk("valid_cycle", cyc, mon_e.at);
            end
        end
        prev_v = RESULT_VALID;
    end

    task automatic tick(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge CLK);
    endtask

    task automatic start(logic step, logic dir, logic [5:0] sel, output int t);
        SCAN_STEP = step;
        SCAN_DIR = dir;
        SCAN_SEL = sel;
        SCAN_START = 1'b1;
        t = cyc;
        @(negedge CLK);
        SCAN_START = 1'b0;
    endtask

    task automatic wait_valid(int lim);
        int n = 0;
        while (!RESULT_VALID && n < lim) begin
            @(negedge CLK);
            n++;
        end
        chk("valid_seen", int'(RESULT_VALID), 1);
    endtask

    task automatic ack();
        RESULT_ACK = 1'b1;
        @(negedge CLK);
        RESULT_ACK = 1'b0;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_psen"}, int'(PSEN), 0);
        chk({tag, "_psincdec"}, int'(PSINCDEC), 0);
        chk({tag, "_result"}, int'(RESULT), 0);
        chk({tag, "_valid"}, int'(RESULT_VALID), 0);
        chk({tag, "_busy"}, int'(BUSY), 0);
        chk({tag, "_pos"}, int'($signed(PHASE_POS)), 0);
        chk({tag, "_timeout"}, int'(PS_TIMEOUT), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, d, e2, exp_pos, pc;
        tick(3);
        chk_reset_vals("rst");
        chk("rst_pos2", int'($signed(pos2)), 32765);
        RST = 1'b0;
        tick(1);
        e2 = 32765;
        for (int k = 0; k < 3; k++) begin
            SCAN_STEP = 1'b1;
            SCAN_DIR = 1'b1;
            SCAN_SEL = 6'd0;
            s2_start = 1'b1;
            tick(1);
            s2_start = 1'b0;
            tick(1);
            s2_done = 1'b1;
            tick(1);
            s2_done = 1'b0;
            for (int i = 0; i < 40 && !valid2; i++) tick(1);
            e2 = e2 == 32767 ? -32768 : e2 + 1;
            chk("valid2", int'(valid2), 1);
            chk("result2", int'(result2), 0);
            chk("pos2_wrap", int'($signed(pos2)), e2);
            s2_ack = 1'b1;
            tick(1);
            s2_ack = 1'b0;
            tick(1);
        end
        exp_pos = 0;
        VCDL_IN = 1'b1;
        start(1'b0, 1'b0, 6'd39, t);
        sb.push_back('{256, t + 273});
        chk("busy_after_start", int'(BUSY), 1);
        wait_until(t + 100);
        start(1'b1, 1'b1, 6'd0, d);
        wait_valid(400);
        chk("psen_never", psen_cnt, 0);
        chk("pos_no_step", int'($signed(PHASE_POS)), exp_pos);
        ack();
        chk("ack_valid_clear", int'(RESULT_VALID), 0);
        chk("ack_busy_clear", int'(BUSY), 0);
        VCDL_IN = 1'b0;
        tog = 1'b1;
        tick(2);
        start(1'b1, 1'b1, 6'd3, t);
        chk("psen_pulse", int'(PSEN), 1);
        chk("psincdec_up", int'(PSINCDEC), 1);
        chk("busy_step", int'(BUSY), 1);
        tick(1);
        chk("psen_one_cycle", int'(PSEN), 0);
        wait_until(t + 13);
        PSDONE = 1'b1;
        d = cyc;
        sb.push_back('{128, d + 273});
        chk("pos_before_done", int'($signed(PHASE_POS)), exp_pos);
        tick(1);
        PSDONE = 1'b0;
        exp_pos++;
        chk("pos_after_done", int'($signed(PHASE_POS)), exp_pos);
        wait_valid(400);
        for (int i = 0; i < 50; i++) begin
            chk("hold_valid", int'(RESULT_VALID), 1);
            chk("hold_result", int'(RESULT), 128);
            tick(1);
        end
        pc = psen_cnt;
        SCAN_STEP = 1'b1;
        SCAN_START = 1'b1;
        RESULT_ACK = 1'b1;
        tick(1);
        SCAN_START = 1'b0;
        RESULT_ACK = 1'b0;
        chk("ack_start_valid", int'(RESULT_VALID), 0);
        chk("ack_start_busy", int'(BUSY), 0);
        tick(1);
        chk("ack_start_ignored", int'(BUSY), 0);
        chk("ack_start_no_psen", psen_cnt, pc);
        tog = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start(1'b1, 1'b0, 6'd40, t);
            chk("psincdec_dn", int'(PSINCDEC), 0);
            wait_until(t + 4);
            PSDONE = 1'b1;
            tick(1);
            PSDONE = 1'b0;
            exp_pos--;
            sb.push_back('{0, -1});
            wait_valid(400);
            ack();
        end
        chk("pos_dec", int'($signed(PHASE_POS)), exp_pos);
        PSDONE = 1'b1;
        tick(1);
        PSDONE = 1'b0;
        tick(2);
        chk("stray_done_pos", int'($signed(PHASE_POS)), exp_pos);
        chk("stray_done_busy", int'(BUSY), 0);
        start(1'b1, 1'b1, 6'd40, t);
        wait_until(t + 1025);
        chk("to_not_yet", int'(PS_TIMEOUT), 0);
        chk("to_busy_wait", int'(BUSY), 1);
        tick(1);
        chk("to_set", int'(PS_TIMEOUT), 1);
        chk("to_busy", int'(BUSY), 0);
        chk("to_pos", int'($signed(PHASE_POS)), exp_pos);
        tick(5);
        chk("to_sticky", int'(PS_TIMEOUT), 1);
        start(1'b0, 1'b0, 6'd40, t);
        chk("to_cleared", int'(PS_TIMEOUT), 0);
        sb.push_back('{0, t + 273});
        wait_valid(400);
        ack();
        VCDL_IN = 1'b1;
        start(1'b0, 1'b0, 6'd40, t);
        wait_until(t + 100);
        RST = 1'b1;
        tick(1);
        chk_reset_vals("mid_rst");
        RST = 1'b0;
        exp_pos = 0;
        tick(1);
        start(1'b1, 1'b1, 6'd40, t);
        tick(1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        PSDONE = 1'b1;
        tick(1);
        PSDONE = 1'b0;
        tick(1);
        chk("abort_done_pos", int'($signed(PHASE_POS)), exp_pos);
        chk("abort_done_busy", int'(BUSY), 0);
        start(1'b0, 1'b0, 6'd40, t);
        sb.push_back('{0, t + 273});
        wait_valid(400);
        ack();
        tick(2);
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
